nasti_line_master: RTL
======================

Name: nasti_line_master

Overview:
- Upstream NASTI master for the behavioural RAM slave (or any NASTI slave).
- Turns one cache-line read or write request on a simple valid/ready port into a single INCR burst on a nasti_channel.
- Collects read beats into a line buffer, or streams a line buffer out as write beats.
- Returns one response per request; one transaction in flight at a time.

Parameters:
ID_WIDTH, 1, width of NASTI id fields; all transactions use id 0
ADDR_WIDTH, 16, byte-address width
DATA_WIDTH, 128, NASTI data width in bits; power of two, 8..256
USER_WIDTH, 1, width of NASTI user fields; driven 0
BEATS, 4, beats per line; power of two, 1..256

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = line write, 0 = line read
req_addr  input  ADDR_WIDTH  byte address; low log2(BEATS*DATA_WIDTH/8) bits ignored
req_wline  input  BEATS*DATA_WIDTH  write line; beat k = bits [k*DATA_WIDTH +: DATA_WIDTH]
resp_valid  output  1  response valid; held until resp_ready
resp_ready  input  1  response consumed
resp_write  output  1  echoes req_write
resp_rline  output  BEATS*DATA_WIDTH  read line, same beat packing; holds last read for writes
resp_err  output  1  SLVERR/DECERR seen, or r_last protocol violation
nasti  nasti_channel.master  -  AW/W/B/AR/R channels

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_err=0; resp_write=0; resp_rline=0.
  - aw_valid, w_valid, ar_valid, b_ready, r_ready=0; beat counter=0.
  - Reset mid-burst abandons the transaction; no response is produced.
- Constant fields:
  - len=BEATS-1; size=log2(DATA_WIDTH/8); burst=INCR (2'b01).
  - id=0, user=0, lock/cache/prot/qos/region=0.
  - w_strb all ones; w_user=0.
- Address alignment: addr = req_addr with the low log2(BEATS*DATA_WIDTH/8) bits cleared.
- FSM states: IDLE, AR, R, AW, W, B, RESP.
  - IDLE: req_ready=1. On acceptance, latch addr, write flag and wline; clear err and beat counter; go to AR (read) or AW (write). req_ready=0 in every other state.
  - AR: ar_valid=1 with fields stable until ar_ready is sampled high; then go to R.
  - R: r_ready=1. Each r_valid && r_ready beat:
    - Store r_data into beat slot[counter]; counter++.
    - err |= r_resp[1].
    - r_last on the final beat (counter==BEATS-1): go to RESP.
    - r_last early: err=1, go to RESP; unfilled slots keep their previous contents.
    - Counter reaches BEATS with no r_last: err=1; keep accepting beats (data discarded, counter saturates) until r_last, then go to RESP.
  - AW: aw_valid=1 until aw_ready; then go to W. W is never issued before AW completes.
  - W: w_valid=1; w_data=slot[counter]; w_last=(counter==BEATS-1).
    - counter advances only on w_valid && w_ready.
    - After the last handshake go to B.
  - B: b_ready=1. On b_valid: err=b_resp[1]; go to RESP.
  - RESP: resp_valid=1 with resp_write, resp_rline and resp_err stable. On resp_ready go to IDLE. A new request is accepted no earlier than the cycle after IDLE is re-entered.
- All NASTI outputs are registered and obey AXI valid/ready rules: once valid is raised, valid and payload hold until the handshake.
- R beats or B responses arriving in any state other than R or B are ignored; r_ready and b_ready are 0 there.
- Minimum latency: read = 1 (AR) + BEATS + 1 cycles to resp_valid; write = 1 + BEATS + 1 + 1.

Test Plan:
- Read with default params, req_addr=0x1234, slave returns beats D0..D3 with r_last on D3 and resp OKAY -> ar_addr=0x1200, ar_len=3, ar_size=4, ar_burst=1; resp_rline={D3,D2,D1,D0}; resp_err=0.
- Write req_addr=0x0040, wline beats W0..W3, slave stalls w_ready 2 cycles on beat 1 -> aw_addr=0x0040; w_data sequence W0,W1(held 3 cycles),W2,W3; w_last only on W3; resp_write=1, resp_err=0.
- Read where the slave sets r_resp=2'b10 on beat 2 -> all 4 beats accepted; resp_err=1.
- Read where r_last arrives on beat 1 -> FSM leaves R after 2 beats; resp_err=1; slots 2..3 unchanged.
- resp_ready held 0 for 5 cycles with req_valid=1 -> resp fields stable; req_ready=0 until 1 cycle after resp handshake.
- rst pulsed during W beat 2 -> all valid and ready outputs 0 immediately; no resp_valid; next request completes normally.

Source files
------------

// File: rtl/nasti_line_master_if.sv
// rtl/nasti_line_master_if.sv - NASTI channel bundle (AW/W/B/AR/R) with master and slave views
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid;
    logic                    r_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );
endinterface

// File: rtl/nasti_line_master.sv
// rtl/nasti_line_master.sv - one cache-line request in, one NASTI INCR burst out, one response back
module nasti_line_master #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1,
    parameter int BEATS      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [BEATS*DATA_WIDTH-1:0]   req_wline,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_write,
    output logic [BEATS*DATA_WIDTH-1:0]   resp_rline,
    output logic                          resp_err,
    nasti_channel.master                  nasti
);
    localparam int SIZE = $clog2(DATA_WIDTH / 8);
    localparam int OFF  = $clog2(BEATS * DATA_WIDTH / 8);
    // Counter is one bit wider than a slot index so it can saturate at BEATS on overrun
    localparam int CW   = $clog2(BEATS) + 1;
    localparam logic [CW-1:0]         LAST_C     = CW'(BEATS - 1);
    localparam logic [CW-1:0]         BEATS_C    = CW'(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

    state_t                        state;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [BEATS*DATA_WIDTH-1:0]   wline_q;
    logic [CW-1:0]                 cnt;
    logic [CW-1:0]                 cnt_inc;
    logic                          ar_valid_q;
    logic                          aw_valid_q;
    logic                          w_valid_q;
    logic                          w_last_q;
    logic [DATA_WIDTH-1:0]         w_data_q;
    logic                          r_ready_q;
    logic                          b_ready_q;

    assign cnt_inc = cnt + 1'b1;

    // Fixed burst shape: single-id, full-width INCR covering exactly one line
    assign nasti.ar_valid  = ar_valid_q;
    assign nasti.ar_id     = '0;
    assign nasti.ar_addr   = addr_q;
    assign nasti.ar_len    = 8'(BEATS - 1);
    assign nasti.ar_size   = 3'(SIZE);
    assign nasti.ar_burst  = 2'b01;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'b0;
    assign nasti.ar_prot   = 3'b0;
    assign nasti.ar_qos    = 4'b0;
    assign nasti.ar_region = 4'b0;
    assign nasti.ar_user   = '0;
    assign nasti.aw_valid  = aw_valid_q;
    assign nasti.aw_id     = '0;
    assign nasti.aw_addr   = addr_q;
    assign nasti.aw_len    = 8'(BEATS - 1);
    assign nasti.aw_size   = 3'(SIZE);
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'b0;
    assign nasti.aw_prot   = 3'b0;
    assign nasti.aw_qos    = 4'b0;
    assign nasti.aw_region = 4'b0;
    assign nasti.aw_user   = '0;
    assign nasti.w_valid   = w_valid_q;
    assign nasti.w_data    = w_data_q;
    assign nasti.w_strb    = '1;
    assign nasti.w_last    = w_last_q;
    assign nasti.w_user    = '0;
    assign nasti.b_ready   = b_ready_q;
    assign nasti.r_ready   = r_ready_q;

    // Response ids/users and the EXOKAY bit carry no information for a single-id master
    logic unused_inputs;
    assign unused_inputs = ^{nasti.b_id, nasti.b_user, nasti.b_resp[0],
                             nasti.r_id, nasti.r_user, nasti.r_resp[0]};

    // Transaction sequencer: request accept, address phase, data beats, response return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
            resp_rline <= '0;
            addr_q     <= '0;
            wline_q    <= '0;
            cnt        <= '0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            w_data_q   <= '0;
            r_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr & ALIGN_MASK;
                        resp_write <= req_write;
                        wline_q    <= req_wline;
                        resp_err   <= 1'b0;
                        cnt        <= '0;
                        req_ready  <= 1'b0;
                        if (req_write) begin
                            aw_valid_q <= 1'b1;
                            state      <= S_AW;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state      <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (nasti.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= S_R;
                    end
                end
                S_R: begin
                    if (nasti.r_valid) begin
                        if (cnt < BEATS_C) begin
                            resp_rline[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= nasti.r_data;
                            cnt <= cnt_inc;
                        end
                        // Early r_last, or a beat past the end without r_last, both flag the line
                        resp_err <= resp_err | nasti.r_resp[1] |
                                    (nasti.r_last ? (cnt != LAST_C) : (cnt >= LAST_C));
                        if (nasti.r_last) begin
                            r_ready_q  <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_AW: begin
                    if (nasti.aw_ready) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b1;
                        w_data_q   <= wline_q[0 +: DATA_WIDTH];
                        w_last_q   <= (BEATS == 1);
                        state      <= S_W;
                    end
                end
                S_W: begin
                    if (nasti.w_ready) begin
                        if (w_last_q) begin
                            w_valid_q <= 1'b0;
                            w_last_q  <= 1'b0;
                            b_ready_q <= 1'b1;
                            state     <= S_B;
                        end else begin
                            cnt      <= cnt_inc;
                            w_data_q <= wline_q[int'(cnt_inc)*DATA_WIDTH +: DATA_WIDTH];
                            w_last_q <= (cnt_inc == LAST_C);
                        end
                    end
                end
                S_B: begin
                    if (nasti.b_valid) begin
                        resp_err   <= nasti.b_resp[1];
                        b_ready_q  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
